lct_l1a_matcher: RTL

Parametrised successor to the fixed-SRL LCT/L1A delay-and-match chain. Stores the LCT (or adjusted CLCT) history in a DEPTH-deep register file tapped at a runtime latency. Matches each L1A against a runtime-programmable asymmetric window and reports hit, hit position and fine-delayed outputs. Sits between the trigger-primitive inputs and the DMB L1A/readout control logic.

---
 rtl/lct_l1a_matcher.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lct_l1a_matcher.sv
`default_nettype none
// ============================================================================
//  Module   : lct_l1a_matcher
//  Purpose  : LCT/L1A delay-and-match. The LCT history (or the adjusted CLCT
//             history) is kept in a DEPTH-deep shift register and tapped at a
//             runtime latency. Each L1A is matched against an asymmetric
//             window around that tap, and the results pass through a
//             programmable fine delay.
//  Options  : define LCT_MATCH_CNT_EN to build saturating L1A and match
//             counters. When it is undefined both counter ports read 0.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module lct_l1a_matcher #(
    parameter int DEPTH  = 512,
    parameter int LAT_W  = 9,
    parameter int MAXW_P = 2,
    parameter int MAXW_M = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             plct_i,
    input  logic             clct_i,
    input  logic             use_clct_i,
    input  logic [3:0]       clct_adj_i,
    input  logic             l1a_i,
    input  logic [LAT_W-1:0] delay_i,
    input  logic [2:0]       win_p_i,
    input  logic [2:0]       win_m_i,
    input  logic [3:0]       l1fd_i,
    output logic             dout_o,
    output logic             match_win_0_o,
    output logic             l1a_match_o,
    output logic [3:0]       match_pos_o,
    output logic             cfg_err_o,
    output logic [15:0]      l1a_cnt_o,
    output logic [15:0]      match_cnt_o
);

    localparam int              c_IW   = $clog2(DEPTH);
    localparam logic [LAT_W:0]  c_D_LO = (LAT_W+1)'(MAXW_P + 1);
    localparam logic [LAT_W:0]  c_D_HI = (LAT_W+1)'(DEPTH - MAXW_M);

    logic [15:0]       clct_pipe_q;
    logic              src;
    logic [DEPTH-1:0]  hist_q;
    logic [LAT_W:0]    delay_ext;
    logic              dly_lo;
    logic              dly_hi;
    logic [LAT_W:0]    d_eff;
    logic [2:0]        win_p_eff;
    logic [2:0]        win_m_eff;
    logic [c_IW-1:0]   ctr_idx;
    logic [c_IW-1:0]   tap_idx;
    logic              ctr_tap;
    logic              any_hit;
    logic [3:0]        hit_pos;
    logic              pre_match_d;
    logic [3:0]        pos_d;
    logic [15:0]       fd_match_q;
    logic [15:0]       fd_win_q;
    logic [15:0][3:0]  fd_pos_q;
    logic              dout_q;
    logic              cfg_err_q;

    // Select the history source; CLCT_ADJ of zero bypasses the CLCT pipe.
    always_comb begin
        src = plct_i;
        if (use_clct_i) begin
            if (clct_adj_i == 4'd0) begin
                src = clct_i;
            end else begin
                src = clct_pipe_q[clct_adj_i - 4'd1];
            end
        end
    end

    // CLCT adjustment pipe and LCT history shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clct_pipe_q <= '0;
            hist_q      <= '0;
        end else begin
            clct_pipe_q <= {clct_pipe_q[14:0], clct_i};
            hist_q      <= {hist_q[DEPTH-2:0], src};
        end
    end

    // Clamp the latency so every window tap stays inside the history.
    always_comb begin
        delay_ext = {1'b0, delay_i};
        dly_lo    = (delay_ext < c_D_LO);
        dly_hi    = (delay_ext > c_D_HI);
        d_eff     = dly_lo ? c_D_LO : (dly_hi ? c_D_HI : delay_ext);
        win_p_eff = (win_p_i > 3'(MAXW_P)) ? 3'(MAXW_P) : win_p_i;
        win_m_eff = (win_m_i > 3'(MAXW_M)) ? 3'(MAXW_M) : win_m_i;
        ctr_idx   = c_IW'(d_eff - (LAT_W+1)'(1));
        ctr_tap   = hist_q[ctr_idx];
    end

    // Scan the window from the outside in so the smallest |k| wins; the
    // negative side is tested after the positive one so it wins a tie.
    always_comb begin
        any_hit = 1'b0;
        hit_pos = 4'd0;
        tap_idx = '0;
        for (int m = 7; m >= 1; m--) begin
            if (m <= MAXW_P && 3'(m) <= win_p_eff) begin
                tap_idx = c_IW'(d_eff - (LAT_W+1)'(m + 1));
                if (hist_q[tap_idx]) begin
                    any_hit = 1'b1;
                    hit_pos = 4'(m);
                end
            end
            if (m <= MAXW_M && 3'(m) <= win_m_eff) begin
                tap_idx = c_IW'(d_eff + (LAT_W+1)'(m) - (LAT_W+1)'(1));
                if (hist_q[tap_idx]) begin
                    any_hit = 1'b1;
                    hit_pos = 4'(-m);
                end
            end
        end
        if (ctr_tap) begin
            any_hit = 1'b1;
            hit_pos = 4'd0;
        end
        pre_match_d = l1a_i & ~rst_i & any_hit;
        pos_d       = pre_match_d ? hit_pos : 4'd0;
    end

    // Fine-delay pipes, registered centre tap and clamp flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fd_match_q <= '0;
            fd_win_q   <= '0;
            fd_pos_q   <= '0;
            dout_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            fd_match_q <= {fd_match_q[14:0], pre_match_d};
            fd_win_q   <= {fd_win_q[14:0], ctr_tap};
            fd_pos_q   <= {fd_pos_q[14:0], pos_d};
            dout_q     <= ctr_tap;
            cfg_err_q  <= dly_lo | dly_hi;
        end
    end

    // Outputs are forced low while reset is held.
    assign dout_o        = dout_q & ~rst_i;
    assign cfg_err_o     = cfg_err_q & ~rst_i;
    assign l1a_match_o   = fd_match_q[l1fd_i] & ~rst_i;
    assign match_win_0_o = fd_win_q[l1fd_i] & ~rst_i;
    assign match_pos_o   = fd_pos_q[l1fd_i] & {4{~rst_i}};

`ifdef LCT_MATCH_CNT_EN
    logic [15:0] l1a_cnt_q;
    logic [15:0] match_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            l1a_cnt_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            if (l1a_i && l1a_cnt_q != 16'hFFFF) begin
                l1a_cnt_q <= l1a_cnt_q + 16'd1;
            end
            if (pre_match_d && match_cnt_q != 16'hFFFF) begin
                match_cnt_q <= match_cnt_q + 16'd1;
            end
        end
    end

    assign l1a_cnt_o   = l1a_cnt_q & {16{~rst_i}};
    assign match_cnt_o = match_cnt_q & {16{~rst_i}};
`else
    assign l1a_cnt_o   = 16'd0;
    assign match_cnt_o = 16'd0;
`endif

endmodule
`default_nettype wire
